// File: rtl/vec_strided_store_unit_if.sv
// Command, VRF read and memory write bus bundle of the strided-store unit.
// The master modport is the store unit itself; slave is the surrounding environment.
interface vec_strided_store_unit_if #(
  parameter int unsigned VL_W   = 8,
  parameter int unsigned VRF_AW = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [31:0]       cmd_base;
  logic [31:0]       cmd_stride;
  logic [VL_W-1:0]   cmd_vl;
  logic [1:0]        cmd_sew;

  logic              vrf_re;
  logic [VRF_AW-1:0] vrf_raddr;
  logic [31:0]       vrf_rdata;

  logic              mem_valid;
  logic              mem_ready;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;

  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  cmd_valid, cmd_base, cmd_stride, cmd_vl, cmd_sew, vrf_rdata, mem_ready,
    output cmd_ready, vrf_re, vrf_raddr, mem_valid, mem_addr, mem_wdata, mem_wstrb,
           busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_base, cmd_stride, cmd_vl, cmd_sew, vrf_rdata, mem_ready,
    input  cmd_ready, vrf_re, vrf_raddr, mem_valid, mem_addr, mem_wdata, mem_wstrb,
           busy, done, err
  );
endinterface

// File: rtl/vec_strided_store_unit.sv
// Strided vector store (vsse.v): reads each element from the VRF and issues one
// masked word write per element at base + i*stride on the data-memory bus.
module vec_strided_store_unit #(
  parameter int unsigned VL_W   = 8,
  parameter int unsigned VRF_AW = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  vec_strided_store_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LOAD  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] SEW_E8  = 2'b00;
  localparam logic [1:0] SEW_E16 = 2'b01;
  localparam logic [1:0] SEW_RSV = 2'b11;

  state_e state_q, state_d;

  logic [31:0]     addr_q, addr_d;
  logic [31:0]     stride_q, stride_d;
  logic [31:0]     elem_q, elem_d;
  logic [VL_W-1:0] vl_q, vl_d;
  logic [VL_W-1:0] idx_q, idx_d;
  logic [1:0]      sew_q, sew_d;
  logic            fail_q, fail_d;

  logic            misalign_c;
  logic            last_c;
  logic [31:0]     lane_elem_c;

  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              vrf_re_q, vrf_re_d;
  logic [VRF_AW-1:0] vrf_raddr_q, vrf_raddr_d;
  logic              mem_valid_q, mem_valid_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic [3:0]        strb_c;

  assign misalign_c = ((sew_q == SEW_E16) && addr_q[0]) ||
                      ((sew_q == 2'b10) && (addr_q[1:0] != 2'b00));
  assign last_c     = (idx_q == (vl_q - VL_W'(1)));

  // Element extraction from the VRF word by the element's position in it
  always_comb begin
    lane_elem_c = bus.vrf_rdata;
    unique case (sew_q)
      SEW_E8:  lane_elem_c = {24'h0, bus.vrf_rdata[{idx_q[1:0], 3'b000} +: 8]};
      SEW_E16: lane_elem_c = {16'h0, bus.vrf_rdata[{idx_q[0], 4'b0000} +: 16]};
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          if ((bus.cmd_sew == SEW_RSV) || (bus.cmd_vl == '0)) state_d = S_DONE;
          else                                               state_d = S_READ;
        end
      end
      S_READ:  state_d = S_LOAD;
      S_LOAD:  state_d = misalign_c ? S_DONE : S_WRITE;
      S_WRITE: if (bus.mem_ready) state_d = last_c ? S_DONE : S_READ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Command/element datapath next values
  always_comb begin
    addr_d   = addr_q;
    stride_d = stride_q;
    elem_d   = elem_q;
    vl_d     = vl_q;
    idx_d    = idx_q;
    sew_d    = sew_q;
    fail_d   = fail_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          addr_d   = bus.cmd_base;
          stride_d = bus.cmd_stride;
          vl_d     = bus.cmd_vl;
          sew_d    = bus.cmd_sew;
          idx_d    = '0;
          fail_d   = (bus.cmd_sew == SEW_RSV);
        end
      end
      S_LOAD: begin
        elem_d = lane_elem_c;
        fail_d = misalign_c;
      end
      S_WRITE: begin
        if (bus.mem_ready) begin
          idx_d  = idx_q + VL_W'(1);
          addr_d = addr_q + stride_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q   <= '0;
      stride_q <= '0;
      elem_q   <= '0;
      vl_q     <= '0;
      idx_q    <= '0;
      sew_q    <= '0;
      fail_q   <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      stride_q <= stride_d;
      elem_q   <= elem_d;
      vl_q     <= vl_d;
      idx_q    <= idx_d;
      sew_q    <= sew_d;
      fail_q   <= fail_d;
    end
  end

  // Output logic: computed from the upcoming state so every output is a flop
  always_comb begin
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_DONE) && fail_d;
    vrf_re_d    = (state_d == S_READ);
    vrf_raddr_d = '0;
    mem_valid_d = (state_d == S_WRITE);
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_wstrb_d = '0;
    unique case (sew_d)
      SEW_E8:  strb_c = 4'b0001;
      SEW_E16: strb_c = 4'b0011;
      default: strb_c = 4'b1111;
    endcase
    if (state_d == S_READ) begin
      unique case (sew_d)
        SEW_E8:  vrf_raddr_d = VRF_AW'(idx_d >> 2);
        SEW_E16: vrf_raddr_d = VRF_AW'(idx_d >> 1);
        default: vrf_raddr_d = VRF_AW'(idx_d);
      endcase
    end
    if (state_d == S_WRITE) begin
      mem_addr_d  = {addr_d[31:2], 2'b00};
      mem_wdata_d = elem_d << {addr_d[1:0], 3'b000};
      mem_wstrb_d = strb_c << addr_d[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      vrf_re_q    <= 1'b0;
      vrf_raddr_q <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      vrf_re_q    <= vrf_re_d;
      vrf_raddr_q <= vrf_raddr_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.vrf_re    = vrf_re_q;
  assign bus.vrf_raddr = vrf_raddr_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_vec_strided_store_unit.sv
// Bench for vec_strided_store_unit: directed and random strided stores checked
// against an element-by-element address/data model, with a randomly stalling responder.
module tb_vec_strided_store_unit;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  logic clk;
  logic resetn;

  vec_strided_store_unit_if #(.VL_W(8), .VRF_AW(8)) bus ();

  vec_strided_store_unit #(.VL_W(8), .VRF_AW(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  logic [31:0] vrf [256];
  wr_t exp_q[$];
  wr_t obs_q[$];

  int n_vec = 0;
  int n_err = 0;
  int fixed_delay = -1;
  bit spur_en = 1'b1;
  int gap = 100;
  bit in_txn = 1'b0;
  int waited = 0;
  int delay = 0;
  wr_t hold;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // VRF: read data valid the cycle after vrf_re
  always @(posedge clk) if (bus.vrf_re) bus.vrf_rdata <= vrf[bus.vrf_raddr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Responder: random wait states, hold checks, spurious ready while idle
  initial begin
    bus.mem_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!bus.mem_valid) begin
        gap++;
        in_txn = 1'b0;
      end
      if (bus.mem_ready) begin
        bus.mem_ready = 1'b0;
      end else if (bus.mem_valid) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          waited = 0;
          hold.addr = bus.mem_addr;
          hold.data = bus.mem_wdata;
          hold.strb = bus.mem_wstrb;
          if (fixed_delay >= 0) delay = fixed_delay;
          else if ($urandom_range(0, 7) == 0) delay = 5;
          else delay = int'($urandom_range(0, 2));
          check("mem_gap", 32'(gap >= 2), 32'd1);
          gap = 0;
        end else begin
          check("hold_addr", bus.mem_addr, hold.addr);
          check("hold_wdata", bus.mem_wdata, hold.data);
          check("hold_wstrb", 32'(bus.mem_wstrb), 32'(hold.strb));
          waited++;
        end
        if (waited >= delay) begin
          bus.mem_ready = 1'b1;
          obs_q.push_back(hold);
          in_txn = 1'b0;
        end
      end else if (spur_en && ($urandom_range(0, 7) == 0)) begin
        bus.mem_ready = 1'b1;
      end
    end
  end

  // Reference: element i lives at byte i*esz of the VRF and goes to base + i*stride
  task automatic build_exp(input logic [31:0] base, input logic [31:0] stride,
                           input logic [7:0] vl, input logic [1:0] sew, output bit err);
    int unsigned esz;
    exp_q.delete();
    err = (sew == 2'b11);
    if (err) return;
    esz = 1 << sew;
    for (int i = 0; i < int'(vl); i++) begin
      logic [31:0] a;
      logic [31:0] word;
      logic [31:0] mask;
      logic [31:0] elem;
      int unsigned boff;
      wr_t w;
      a    = base + 32'(i) * stride;
      boff = 32'(i) * esz;
      word = vrf[boff / 4];
      mask = (esz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * esz)) - 32'h1);
      elem = (word >> (8 * (boff % 4))) & mask;
      if ((a % esz) != 0) begin
        err = 1'b1;
        break;
      end
      w.addr = a - (a % 4);
      w.data = elem << (8 * (a % 4));
      w.strb = 4'(((1 << esz) - 1) << (a % 4));
      exp_q.push_back(w);
    end
  endtask

  task automatic run_cmd(input logic [31:0] base, input logic [31:0] stride,
                         input logic [7:0] vl, input logic [1:0] sew);
    bit exp_err;
    bit seen;
    bit junk;
    int c;
    int n;
    build_exp(base, stride, vl, sew, exp_err);
    obs_q.delete();
    @(negedge clk);
    check("cmd_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_base   = base;
    bus.cmd_stride = stride;
    bus.cmd_vl     = vl;
    bus.cmd_sew    = sew;
    junk = ($urandom_range(0, 3) == 0);
    seen = 1'b0;
    for (c = 1; c <= 3000; c++) begin
      @(negedge clk);
      if (c == 1 || c == 4) bus.cmd_valid = 1'b0;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (c == 3 && junk) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_base  = $urandom;
        bus.cmd_vl    = 8'd200;
        bus.cmd_sew   = 2'b00;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    if (vl == 8'd0 || sew == 2'b11) check("done_latency", 32'(c), 32'd1);
    check("err", 32'(bus.err), 32'(exp_err));
    check("busy_at_done", 32'(bus.busy), 32'd1);
    check("n_writes", 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("wr%0d_addr", i), obs_q[i].addr, exp_q[i].addr);
      check($sformatf("wr%0d_wdata", i), obs_q[i].data, exp_q[i].data);
      check($sformatf("wr%0d_wstrb", i), 32'(obs_q[i].strb), 32'(exp_q[i].strb));
    end
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 32'd0);
    check("idle_ready", 32'(bus.cmd_ready), 32'd1);
    check("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bit found;
    resetn         = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_base   = '0;
    bus.cmd_stride = '0;
    bus.cmd_vl     = '0;
    bus.cmd_sew    = '0;
    for (int i = 0; i < 256; i++) vrf[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_vrf_re", 32'(bus.vrf_re), 32'd0);
    check("rst_vrf_raddr", 32'(bus.vrf_raddr), 32'd0);
    check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
    resetn = 1'b1;

    vrf[0] = 32'h4433_2211;
    run_cmd(32'd400, 32'd4, 8'd4, 2'b00);
    vrf[0] = 32'h00CC_BBAA;
    run_cmd(32'd401, 32'd2, 8'd3, 2'b00);
    vrf[0] = 32'hBBBB_AAAA;
    vrf[1] = 32'h0000_CCCC;
    run_cmd(32'h200, 32'd6, 8'd3, 2'b01);
    vrf[2] = 32'h1234_5678;
    run_cmd(32'h3FC, 32'hFFFF_FFFC, 8'd3, 2'b10);
    run_cmd(32'h102, 32'd4, 8'd2, 2'b10);
    run_cmd(32'h201, 32'd2, 8'd2, 2'b01);
    fixed_delay = 5;
    vrf[0] = 32'h4433_2211;
    run_cmd(32'd400, 32'd4, 8'd4, 2'b00);
    fixed_delay = -1;
    run_cmd(32'h1000, 32'd4, 8'd0, 2'b00);
    run_cmd(32'h1000, 32'd4, 8'd3, 2'b11);
    run_cmd(32'hFFFF_FFF8, 32'd4, 8'd4, 2'b10);

    for (int i = 0; i < 256; i++) vrf[i] = $urandom;
    for (int k = 0; k < 60; k++) begin
      logic [1:0]  sew;
      int unsigned esz;
      int          s;
      logic [31:0] base;
      logic [7:0]  vl;
      sew  = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      esz  = (sew == 2'b11) ? 1 : (1 << sew);
      vl   = 8'($urandom_range(0, 12));
      s    = int'($urandom_range(0, 16)) - 8;
      base = $urandom;
      if ($urandom_range(0, 4) != 0) begin
        base = base & ~32'(esz - 1);
        s    = s * int'(esz);
      end
      run_cmd(base, 32'(s), vl, sew);
    end

    // Reset while a write is outstanding, then a clean command
    fixed_delay = 30;
    spur_en     = 1'b0;
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_base   = 32'h100;
    bus.cmd_stride = 32'd4;
    bus.cmd_vl     = 8'd4;
    bus.cmd_sew    = 2'b10;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.mem_valid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rst_mid_valid_seen", 32'(found), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    check("rst_mid_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("rst_mid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_done", 32'(bus.done), 32'd0);
    resetn      = 1'b1;
    fixed_delay = -1;
    spur_en     = 1'b1;
    run_cmd(32'h100, 32'd4, 8'd4, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
